// File: rtl/pb_port_master.sv
// Command-driven Picoblaze port-bus initiator reproducing the CPU two-cycle OUTPUT/INPUT timing.
// Optional multi-beat bursts are compiled in when PB_PORT_MASTER_BURST_EN is defined.
module pb_port_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [3:0] cmd_len,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] in_port,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] WAIT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  logic [2:0] state_q, state_d;
  logic       write_q, write_d;
  logic [3:0] len_q, len_d;
  logic [3:0] beat_q, beat_d;
  logic [1:0] wait_q, wait_d;
  logic [7:0] port_id_q, port_id_d;
  logic [7:0] out_port_q, out_port_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       wstb_q, wstb_d;
  logic       rstb_q, rstb_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       busy_q, busy_d;
  logic       more;

`ifndef PB_PORT_MASTER_BURST_EN
  logic unused_len;
  assign unused_len = ^cmd_len;
`endif

  assign more = (beat_q != len_q);

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    port_id_d  = port_id_q;
    out_port_d = out_port_q;
    rsp_data_d = rsp_data_q;
    wstb_d     = 1'b0;
    rstb_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d    = cmd_write;
`ifdef PB_PORT_MASTER_BURST_EN
          len_d      = cmd_len;
`else
          len_d      = 4'd0;
`endif
          beat_d     = 4'd0;
          port_id_d  = cmd_addr;
          out_port_d = cmd_data;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        wstb_d  = write_q;
        rstb_d  = ~write_q;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (write_q) begin
          if (more) begin
            beat_d    = beat_q + 4'd1;
            port_id_d = port_id_q + 8'd1;
            state_d   = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (READ_LATENCY == 0) begin
          rsp_data_d = in_port;
          state_d    = S_RESP;
        end else begin
          wait_d  = 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          rsp_data_d = in_port;
          state_d    = S_RESP;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_RESP: begin
        // next beat's SETUP only after this beat's response is taken
        if (rsp_ready) begin
          if (more) begin
            beat_d    = beat_q + 4'd1;
            port_id_d = port_id_q + 8'd1;
            state_d   = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      wait_q      <= 2'd0;
      port_id_q   <= 8'd0;
      out_port_q  <= 8'd0;
      rsp_data_q  <= 8'd0;
      wstb_q      <= 1'b0;
      rstb_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      port_id_q   <= port_id_d;
      out_port_q  <= out_port_d;
      rsp_data_q  <= rsp_data_d;
      wstb_q      <= wstb_d;
      rstb_q      <= rstb_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign port_id      = port_id_q;
  assign out_port     = out_port_q;
  assign write_strobe = wstb_q;
  assign read_strobe  = rstb_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pb_port_master.sv
// Directed + randomized bench for pb_port_master against a port-mapped memory responder
// and a command-level reference of memory contents.
module tb_pb_port_master;

  localparam int RL = 1;
`ifdef PB_PORT_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] cmd_len = 4'h0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       busy;

  int total = 0;
  int bad = 0;

  pb_port_master #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .in_port(in_port), .busy(busy)
  );

  always #5 clk = ~clk;

  // responder: registered read data, zero except the cycle after read_strobe
  logic [7:0] bus_mem [256] = '{default: 8'h00};
  logic [7:0] rd_dat = 8'h00;
  always @(posedge clk) begin
    if (write_strobe) bus_mem[port_id] <= out_port;
    rd_dat <= read_strobe ? bus_mem[port_id] : 8'h00;
  end
  assign in_port = rd_dat;

  logic [7:0] ref_mem [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input logic [3:0] l);
    int beats;
    int cnt;
    int hold;
    logic [7:0] ea;
    logic [7:0] ed;
    beats = BURST ? int'(l) + 1 : 1;
    cnt = 0;
    while (!cmd_ready && cnt < 20) begin tick(); cnt++; end
    chk("ready_wait", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d; cmd_len = l;
    tick();
    cmd_valid = 1'b0; cmd_write = ~w;
    cmd_addr = 8'($urandom); cmd_data = 8'($urandom); cmd_len = 4'($urandom);
    for (int k = 0; k < beats; k++) begin
      ea = a + 8'(k);
      cnt = 0;
      while (!(write_strobe || read_strobe) && cnt < 20) begin tick(); cnt++; end
      chk("strobe_seen", {31'd0, write_strobe || read_strobe}, 1);
      chk("beat_addr", {24'd0, port_id}, {24'd0, ea});
      chk("wr_stb", {31'd0, write_strobe}, {31'd0, w});
      chk("rd_stb", {31'd0, read_strobe}, {31'd0, ~w});
      if (w) begin
        chk("wr_data", {24'd0, out_port}, {24'd0, d});
        chk("wr_norsp", {31'd0, rsp_valid}, 0);
        ref_mem[ea] = d;
        tick();
      end else begin
        ed = ref_mem[ea];
        tick();
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin tick(); cnt++; end
        chk("rsp_lat", cnt, RL);
        hold = $urandom_range(0, 3);
        rsp_ready = 1'b0;
        repeat (hold) begin
          tick();
          chk("rsp_hold", {31'd0, rsp_valid}, 1);
        end
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, ed});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'd0, rsp_valid}, 0);
      end
    end
    chk("end_ready", {31'd0, cmd_ready}, 1);
    chk("end_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    int acc;
    bit seen;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_ready", {31'd0, cmd_ready}, 0);
    chk("rst_outs", {8'd0, port_id, out_port, rsp_data}, 0);
    chk("rst_flags", {28'd0, rsp_valid, write_strobe, read_strobe, busy}, 0);
    reset = 1'b0;
    tick();
    chk("rel_ready", {31'd0, cmd_ready}, 1);

    // directed write 0x5A -> 0x08, cycle-accurate
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h08; cmd_data = 8'h5A; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    chk("w_c1_id", {24'd0, port_id}, 32'h08);
    chk("w_c1_out", {24'd0, out_port}, 32'h5A);
    chk("w_c1_stb", {30'd0, write_strobe, read_strobe}, 0);
    chk("w_c1_ready", {31'd0, cmd_ready}, 0);
    tick();
    chk("w_c2_stb", {30'd0, write_strobe, read_strobe}, 2);
    tick();
    chk("w_c3_ready", {31'd0, cmd_ready}, 1);
    chk("w_c3_rsp", {31'd0, rsp_valid}, 0);
    ref_mem[8'h08] = 8'h5A;

    run_cmd(1'b0, 8'h08, 8'h00, 4'd0);
    run_cmd(1'b1, 8'h08, 8'hA5, 4'd0);

    // directed read of 0x08 with 5 cycles of response backpressure
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
    tick();
    cmd_valid = 1'b0;
    chk("r_c1_id", {24'd0, port_id}, 32'h08);
    chk("r_c1_stb", {30'd0, write_strobe, read_strobe}, 0);
    tick();
    chk("r_c2_stb", {30'd0, write_strobe, read_strobe}, 1);
    tick();
    chk("r_c3_rsp", {31'd0, rsp_valid}, 0);
    chk("r_c3_id", {24'd0, port_id}, 32'h08);
    tick();
    chk("r_c4_rsp", {31'd0, rsp_valid}, 1);
    chk("r_c4_data", {24'd0, rsp_data}, 32'hA5);
    repeat (5) begin
      tick();
      chk("r_hold_v", {31'd0, rsp_valid}, 1);
      chk("r_hold_d", {24'd0, rsp_data}, 32'hA5);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("r_idle_ready", {31'd0, cmd_ready}, 1);
    chk("r_idle_rsp", {30'd0, rsp_valid, busy}, 0);

    // cmd_valid held high through a read: one accept only
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08; rsp_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      if (cmd_valid && cmd_ready) acc++;
      tick();
    end
    chk("hold_accepts", acc, 1);
    chk("hold_ready_again", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b0; rsp_ready = 1'b0;

    // reset pulsed while in WAIT
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("wrst_ready", {31'd0, cmd_ready}, 0);
    chk("wrst_outs", {8'd0, port_id, out_port, rsp_data}, 0);
    chk("wrst_flags", {28'd0, rsp_valid, write_strobe, read_strobe, busy}, 0);
    reset = 1'b0;
    seen = 1'b0;
    tick();
    chk("wrst_rel_ready", {31'd0, cmd_ready}, 1);
    repeat (6) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    chk("wrst_no_rsp", {31'd0, seen}, 0);

    // wrap-around burst (single beat when bursts are compiled out)
    run_cmd(1'b1, 8'hFE, 8'h3C, 4'd2);
    run_cmd(1'b0, 8'hFE, 8'h00, 4'd2);

    // randomized mix around the address wrap point
    for (int n = 0; n < 40; n++) begin
      run_cmd(1'($urandom_range(0, 1)), 8'hFC + 8'($urandom_range(0, 7)),
              8'($urandom), 4'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
